// File: rtl/concat_rd_resp_fifo.sv
// rtl/concat_rd_resp_fifo.sv - read-response FIFO between MCIF and Concat with burst credit tracking
// Registered head output; outstanding beats are tracked so requests are only issued when a full burst fits.
module concat_rd_resp_fifo #(
    parameter int DW = 256,
    parameter int AW = 4,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          req_fire,
    input  logic [LW-1:0] req_len,
    output logic          credit_ok,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [DW-1:0] in_pd,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_pd,
    output logic          pop,
    output logic [AW:0]   count,
    output logic [AW:0]   outstanding,
    output logic          ovf_err
);

    localparam int DEPTH = 1 << AW;
    localparam int CAP   = (LW >= AW) ? DEPTH : (1 << LW);
    // Wide enough that req_len+1 plus the counters can never wrap.
    localparam int SW    = AW + LW + 3;
    localparam logic [SW-1:0] OMAX = SW'((1 << (AW + 1)) - 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW:0]   count_nxt;
    logic [AW:0]   outstanding_nxt;
    logic [SW-1:0] fire_len;
    logic [SW-1:0] out_sum;
    logic [SW-1:0] out_lo;
    logic          push;
    logic          fire;
    logic          ovf_set;
    logic          credit_nxt;

    assign in_rdy  = (count != FULL);
    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy;
    assign push    = in_vld & in_rdy & ~start;
    assign fire    = req_fire & ~start;

    always_comb begin
        count_nxt  = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        rd_ptr_nxt = rd_ptr + {{(AW-1){1'b0}}, pop};
        fire_len   = fire ? (SW'(req_len) + SW'(1)) : '0;
        out_sum    = SW'(outstanding) + fire_len;
        if (push && (out_sum == '0)) begin
            out_lo = '0;
        end else begin
            out_lo = out_sum - SW'(push);
        end
        outstanding_nxt = (out_lo > OMAX) ? {(AW+1){1'b1}} : out_lo[AW:0];
        ovf_set = (push && (outstanding == '0) && !fire)
                  || ((SW'(count_nxt) + out_lo) > SW'(DEPTH));
        credit_nxt = (SW'(count_nxt) + SW'(outstanding_nxt) + SW'(CAP)) <= SW'(DEPTH);
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_pd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            ovf_err     <= 1'b0;
            credit_ok   <= 1'b1;
            out_pd      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            outstanding <= outstanding_nxt;
            ovf_err     <= ovf_err | ovf_set;
            credit_ok   <= credit_nxt;
            // New head is the beat being written when it lands exactly at the next read slot.
            if (pop || (push && (count == '0))) begin
                out_pd <= (push && (rd_ptr_nxt == wr_ptr)) ? in_pd : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: tb/tb_concat_rd_resp_fifo.sv
// tb/tb_concat_rd_resp_fifo.sv - directed self-checking bench for concat_rd_resp_fifo
module tb_concat_rd_resp_fifo;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          req_fire;
    logic [LW-1:0] req_len;
    logic          credit_ok;
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_pd;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_pd;
    logic          pop;
    logic [AW:0]   count;
    logic [AW:0]   outstanding;
    logic          ovf_err;

    int tests = 0;
    int fails = 0;

    concat_rd_resp_fifo #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .req_fire(req_fire), .req_len(req_len),
        .credit_ok(credit_ok), .in_vld(in_vld), .in_rdy(in_rdy), .in_pd(in_pd),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_pd(out_pd), .pop(pop),
        .count(count), .outstanding(outstanding), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start = 0; req_fire = 0; req_len = '0; in_vld = 0; in_pd = '0; out_rdy = 0;
    endtask

    task automatic pulse_start;
        start = 1; tick; start = 0;
    endtask

    task automatic test_reset;
        rst = 0;
        req_fire = 1; req_len = 8'd5; in_vld = 1; in_pd = 32'hAA; out_rdy = 0;
        tick; tick; tick;
        idle_inputs;
        in_vld = 1; out_rdy = 1;
        rst = 1; tick; tick;
        in_vld = 0;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
        tests++; if (outstanding !== 5'd0) begin fails++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL rst_out_vld got %b exp 0", out_vld); end
        tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL rst_in_rdy got %b exp 1", in_rdy); end
        tests++; if (credit_ok !== 1'b1) begin fails++; $display("FAIL rst_credit_ok got %b exp 1", credit_ok); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL rst_ovf_err got %b exp 0", ovf_err); end
        tests++; if (out_pd !== 32'd0) begin fails++; $display("FAIL rst_out_pd got %h exp 0", out_pd); end
        #1;
        tests++; if (pop !== 1'b0) begin fails++; $display("FAIL rst_pop got %b exp 0", pop); end
        rst = 0; out_rdy = 0;
        tick;
    endtask

    task automatic test_fill_drain;
        req_fire = 1; req_len = 8'd15; tick; req_fire = 0;
        tests++; if (outstanding !== 5'd16) begin fails++; $display("FAIL fd_outstanding got %0d exp 16", outstanding); end
        for (int i = 0; i < 16; i++) begin
            in_vld = 1; in_pd = 32'(i); tick;
        end
        in_vld = 0;
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL fd_count_full got %0d exp 16", count); end
        tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL fd_in_rdy got %b exp 0", in_rdy); end
        tests++; if (credit_ok !== 1'b0) begin fails++; $display("FAIL fd_credit_ok got %b exp 0", credit_ok); end
        tests++; if (outstanding !== 5'd0) begin fails++; $display("FAIL fd_outstanding_end got %0d exp 0", outstanding); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL fd_ovf_err got %b exp 0", ovf_err); end
        out_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            tests++; if (out_vld !== 1'b1 || out_pd !== 32'(i)) begin fails++; $display("FAIL fd_drain[%0d] got vld=%b pd=%0d exp vld=1 pd=%0d", i, out_vld, out_pd, i); end
            tick;
        end
        out_rdy = 0;
        tests++; if (count !== 5'd0 || out_vld !== 1'b0) begin fails++; $display("FAIL fd_empty got count=%0d vld=%b exp 0/0", count, out_vld); end
        tests++; if (credit_ok !== 1'b1) begin fails++; $display("FAIL fd_credit_back got %b exp 1", credit_ok); end
    endtask

    task automatic test_latency_wrap;
        pulse_start;
        tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL lw_pre_vld got %b exp 0", out_vld); end
        out_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            in_vld = 1; in_pd = 32'(100 + i); tick;
            tests++; if (out_vld !== 1'b1 || out_pd !== 32'(100 + i) || count !== 5'd1) begin
                fails++; $display("FAIL lw_beat[%0d] got vld=%b pd=%0d count=%0d exp 1/%0d/1", i, out_vld, out_pd, count, 100 + i);
            end
        end
        in_vld = 0; tick; out_rdy = 0;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL lw_final_count got %0d exp 0", count); end
    endtask

    task automatic test_credits;
        pulse_start;
        req_fire = 1; req_len = 8'd7; tick;
        tests++; if (outstanding !== 5'd8) begin fails++; $display("FAIL cr_out_8 got %0d exp 8", outstanding); end
        req_len = 8'd3; tick; req_fire = 0;
        tests++; if (outstanding !== 5'd12) begin fails++; $display("FAIL cr_out_12 got %0d exp 12", outstanding); end
        tests++; if (credit_ok !== 1'b0) begin fails++; $display("FAIL cr_credit_low got %b exp 0", credit_ok); end
        out_rdy = 1;
        for (int i = 0; i < 12; i++) begin
            in_vld = 1; in_pd = 32'(i); tick;
        end
        in_vld = 0; tick; out_rdy = 0;
        tests++; if (outstanding !== 5'd0 || count !== 5'd0) begin fails++; $display("FAIL cr_drained got out=%0d count=%0d exp 0/0", outstanding, count); end
        tests++; if (credit_ok !== 1'b1) begin fails++; $display("FAIL cr_credit_high got %b exp 1", credit_ok); end
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL cr_ovf_err got %b exp 0", ovf_err); end
    endtask

    task automatic test_error;
        pulse_start;
        tests++; if (ovf_err !== 1'b0) begin fails++; $display("FAIL er_pre got %b exp 0", ovf_err); end
        in_vld = 1; in_pd = 32'd5; tick; in_vld = 0;
        tests++; if (ovf_err !== 1'b1 || count !== 5'd1) begin fails++; $display("FAIL er_set got ovf=%b count=%0d exp 1/1", ovf_err, count); end
        tick; tick;
        tests++; if (ovf_err !== 1'b1) begin fails++; $display("FAIL er_sticky got %b exp 1", ovf_err); end
        start = 1; in_vld = 1; in_pd = 32'd9; req_fire = 1; req_len = 8'd3; tick;
        start = 0; in_vld = 0; req_fire = 0;
        tests++; if (ovf_err !== 1'b0 || count !== 5'd0 || out_vld !== 1'b0) begin fails++; $display("FAIL er_start got ovf=%b count=%0d vld=%b exp 0/0/0", ovf_err, count, out_vld); end
        tests++; if (outstanding !== 5'd0) begin fails++; $display("FAIL er_start_out got %0d exp 0", outstanding); end
    endtask

    task automatic test_simultaneous;
        pulse_start;
        req_fire = 1; req_len = 8'd15; tick; req_fire = 0;
        for (int i = 0; i < 16; i++) begin
            in_vld = 1; in_pd = 32'(200 + i); tick;
        end
        in_pd = 32'd300; out_rdy = 1; #1;
        tests++; if (pop !== 1'b1 || in_rdy !== 1'b0) begin fails++; $display("FAIL sm_full got pop=%b in_rdy=%b exp 1/0", pop, in_rdy); end
        tick;
        tests++; if (count !== 5'd15 || out_pd !== 32'd201) begin fails++; $display("FAIL sm_pop got count=%0d pd=%0d exp 15/201", count, out_pd); end
        out_rdy = 0; tick; in_vld = 0;
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL sm_write got count=%0d exp 16", count); end
        out_rdy = 1;
        for (int i = 0; i < 16; i++) begin
            tests++; if (out_pd !== ((i == 15) ? 32'd300 : 32'(201 + i))) begin fails++; $display("FAIL sm_drain[%0d] got %0d exp %0d", i, out_pd, (i == 15) ? 300 : 201 + i); end
            tick;
        end
        out_rdy = 0;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL sm_empty got %0d exp 0", count); end
    endtask

    initial begin
        idle_inputs;
        rst = 1;
        tick; tick;
        test_reset;
        test_fill_drain;
        test_latency_wrap;
        test_credits;
        test_error;
        test_simultaneous;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
